dlock_ctrl_p: RTL and testbench

Parametrised digital-lock controller: the next-generation single-block replacement for the lock/unlock, new-password and error-count logic in the board-level lock top. It collects keypad digits into an entry buffer and checks them against a stored password. It counts failed attempts, enforces a timed lockout after a configurable number of failures, and lets the user change the password while unlocked. Digit count, digit width, error limit and lockout length are parameters; the 7-segment driver and button debouncers stay outside and feed it one-cycle pulses.

---
 rtl/dlock_pkg.sv | 25 ++
 rtl/dlock_digit_shreg.sv | 68 ++++++
 rtl/dlock_ctrl_p.sv | 170 +++++++++++++++++
 tb/tb_dlock_ctrl_p.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dlock_pkg.sv
// Shared types and constants for the digital-lock controller: state
// enumeration, status colours and the counter-width helper.
package dlock_pkg;

    typedef enum logic [2:0] {
        ST_ENTRY    = 3'd0,
        ST_CHECK    = 3'd1,
        ST_UNLOCKED = 3'd2,
        ST_SET      = 3'd3,
        ST_LOCKOUT  = 3'd4
    } dlock_state_e;

    // Status colours, bit order {R,G,B}
    localparam logic [2:0] RGB_ENTRY   = 3'b001;
    localparam logic [2:0] RGB_SET     = 3'b011;
    localparam logic [2:0] RGB_OPEN    = 3'b010;
    localparam logic [2:0] RGB_LOCKOUT = 3'b100;
    localparam logic [2:0] RGB_OFF     = 3'b000;

    // Bits needed to hold any value 0..max_val (never less than 1)
    function automatic int cnt_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/dlock_digit_shreg.sv
// Digit entry buffer shared by password entry and password change:
// left-shifting digit register, saturating digit counter and clear.
// Build option DLOCK_MASK_EN: the display copy shows all-ones per entered
// digit instead of the digit itself; the real digits stay internal.
module dlock_digit_shreg
    import dlock_pkg::*;
#(
    parameter int DIGITS  = 4,
    parameter int DIGIT_W = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         i_clear,
    input  logic                         i_push,
    input  logic [DIGIT_W-1:0]           i_digit,
    output logic [DIGITS*DIGIT_W-1:0]    o_buf,
    output logic [DIGITS*DIGIT_W-1:0]    o_disp,
    output logic [cnt_w(DIGITS)-1:0]     o_cnt,
    output logic                         o_full
);

    localparam int BW = DIGITS * DIGIT_W;
    localparam int CW = cnt_w(DIGITS);

    logic [BW-1:0] r_buf;
    logic [CW-1:0] r_cnt;
    logic          w_full;

    assign w_full = (r_cnt == CW'(DIGITS));

    // Real digits and count: clear wins, pushes beyond a full buffer are dropped
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_buf <= '0;
            r_cnt <= '0;
        end else if (i_clear) begin
            r_buf <= '0;
            r_cnt <= '0;
        end else if (i_push && !w_full) begin
            r_buf <= (r_buf << DIGIT_W) | BW'(i_digit);
            r_cnt <= r_cnt + CW'(1);
        end
    end

`ifdef DLOCK_MASK_EN
    logic [BW-1:0] r_disp;

    // Masked display copy: one all-ones digit per entered position
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_disp <= '0;
        end else if (i_clear) begin
            r_disp <= '0;
        end else if (i_push && !w_full) begin
            r_disp <= (r_disp << DIGIT_W) | BW'({DIGIT_W{1'b1}});
        end
    end

    assign o_disp = r_disp;
`else
    assign o_disp = r_buf;
`endif

    assign o_buf  = r_buf;
    assign o_cnt  = r_cnt;
    assign o_full = w_full;

endmodule

// File: rtl/dlock_ctrl_p.sv
// Digital-lock controller top: control FSM, password register, failed
// attempt counter and lockout timer around the shared digit buffer.
// Build option DLOCK_MASK_EN masks the digits shown on entry_buf.
//
// Inputs digit_vld/confirm/exit are one-cycle pulses with no ready path:
// a pulse is consumed on the edge it is high, and any pulse arriving while
// the FSM is in CHECK or LOCKOUT is lost. Same-cycle priority is
// exit > confirm > digit_vld; the lower pulses of that cycle are dropped.
module dlock_ctrl_p
    import dlock_pkg::*;
#(
    parameter int                           DIGITS      = 4,
    parameter int                           DIGIT_W     = 4,
    parameter int                           MAX_ERR     = 3,
    parameter int                           LOCKOUT_CYC = 1000,
    parameter logic [DIGITS*DIGIT_W-1:0]    DEFAULT_PW  = '0
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic [DIGIT_W-1:0]              digit_in,
    input  logic                            digit_vld,
    input  logic                            confirm,
    input  logic                            exit,
    output logic                            lock_status,
    output logic [DIGITS*DIGIT_W-1:0]       entry_buf,
    output logic [cnt_w(DIGITS)-1:0]        digit_cnt,
    output logic [cnt_w(MAX_ERR)-1:0]       err_cnt,
    output logic [cnt_w(LOCKOUT_CYC)-1:0]   lockout_left,
    output logic [2:0]                      rgb,
    output dlock_state_e                    dbg_state
);

    localparam int BW = DIGITS * DIGIT_W;
    localparam int CW = cnt_w(DIGITS);
    localparam int EW = cnt_w(MAX_ERR);
    localparam int LW = cnt_w(LOCKOUT_CYC);

    dlock_state_e  r_state;
    logic [BW-1:0] r_pw;
    logic [EW-1:0] r_err;
    logic [LW-1:0] r_left;
    logic          r_lock;
    logic [2:0]    r_rgb;

    logic [BW-1:0] w_buf;
    logic [BW-1:0] w_disp;
    logic [CW-1:0] w_cnt;
    logic          w_full;
    logic          w_push;
    logic          w_clear;
    logic [EW-1:0] w_err_inc;

    assign w_err_inc = r_err + EW'(1);

    dlock_digit_shreg #(
        .DIGITS  (DIGITS),
        .DIGIT_W (DIGIT_W)
    ) u_shreg (
        .clk     (clk),
        .reset_n (reset_n),
        .i_clear (w_clear),
        .i_push  (w_push),
        .i_digit (digit_in),
        .o_buf   (w_buf),
        .o_disp  (w_disp),
        .o_cnt   (w_cnt),
        .o_full  (w_full)
    );

    // Buffer control: digits only land in ENTRY/SET, and only when no higher pulse is present
    always_comb begin
        w_push  = 1'b0;
        w_clear = 1'b0;
        case (r_state)
            ST_ENTRY: begin
                if (exit)           w_clear = 1'b1;
                else if (!confirm)  w_push  = digit_vld;
            end
            ST_CHECK: w_clear = 1'b1;
            ST_SET: begin
                if (exit)           w_clear = 1'b1;
                else if (confirm)   w_clear = w_full;
                else                w_push  = digit_vld;
            end
            default: ;
        endcase
    end

    // Control FSM with registered status outputs, password, error count and lockout timer
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_ENTRY;
            r_pw    <= DEFAULT_PW;
            r_err   <= '0;
            r_left  <= '0;
            r_lock  <= 1'b0;
            r_rgb   <= RGB_ENTRY;
        end else begin
            case (r_state)
                ST_ENTRY: begin
                    if (!exit && confirm && w_full) begin
                        r_state <= ST_CHECK;
                        r_rgb   <= RGB_OFF;
                    end
                end
                ST_CHECK: begin
                    if (w_buf == r_pw) begin
                        r_state <= ST_UNLOCKED;
                        r_err   <= '0;
                        r_lock  <= 1'b1;
                        r_rgb   <= RGB_OPEN;
                    end else if (w_err_inc == EW'(MAX_ERR)) begin
                        r_state <= ST_LOCKOUT;
                        r_err   <= w_err_inc;
                        r_left  <= LW'(LOCKOUT_CYC);
                        r_rgb   <= RGB_LOCKOUT;
                    end else begin
                        r_state <= ST_ENTRY;
                        r_err   <= w_err_inc;
                        r_rgb   <= RGB_ENTRY;
                    end
                end
                ST_UNLOCKED: begin
                    if (exit) begin
                        r_state <= ST_ENTRY;
                        r_lock  <= 1'b0;
                        r_rgb   <= RGB_ENTRY;
                    end else if (confirm) begin
                        r_state <= ST_SET;
                        r_rgb   <= RGB_SET;
                    end
                end
                ST_SET: begin
                    if (exit) begin
                        r_state <= ST_UNLOCKED;
                        r_rgb   <= RGB_OPEN;
                    end else if (confirm && w_full) begin
                        r_pw    <= w_buf;
                        r_state <= ST_UNLOCKED;
                        r_rgb   <= RGB_OPEN;
                    end
                end
                ST_LOCKOUT: begin
                    if (r_left == LW'(1)) begin
                        r_state <= ST_ENTRY;
                        r_left  <= '0;
                        r_err   <= '0;
                        r_rgb   <= RGB_ENTRY;
                    end else begin
                        r_left  <= r_left - LW'(1);
                    end
                end
                default: begin
                    r_state <= ST_ENTRY;
                    r_lock  <= 1'b0;
                    r_rgb   <= RGB_ENTRY;
                end
            endcase
        end
    end

    assign lock_status  = r_lock;
    assign entry_buf    = w_disp;
    assign digit_cnt    = w_cnt;
    assign err_cnt      = r_err;
    assign lockout_left = r_left;
    assign rgb          = r_rgb;
    assign dbg_state    = r_state;

endmodule

// File: tb/tb_dlock_ctrl_p.sv
// Self-checking bench for dlock_ctrl_p: directed steps followed by random
// pulses, every cycle compared against a behavioural model of the lock.
module tb_dlock_ctrl_p;

  localparam int DIGITS      = 4;
  localparam int DIGIT_W     = 4;
  localparam int MAX_ERR     = 3;
  localparam int LOCKOUT_CYC = 8;
  localparam logic [15:0] PW0 = 16'h1234;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]  digit_in = '0;
  logic        digit_vld = 1'b0;
  logic        confirm = 1'b0;
  logic        exit = 1'b0;
  logic        lock_status;
  logic [15:0] entry_buf;
  logic [2:0]  digit_cnt;
  logic [1:0]  err_cnt;
  logic [3:0]  lockout_left;
  logic [2:0]  rgb;
  dlock_pkg::dlock_state_e dbg_state;

  dlock_ctrl_p #(
    .DIGITS      (DIGITS),
    .DIGIT_W     (DIGIT_W),
    .MAX_ERR     (MAX_ERR),
    .LOCKOUT_CYC (LOCKOUT_CYC),
    .DEFAULT_PW  (PW0)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .digit_in     (digit_in),
    .digit_vld    (digit_vld),
    .confirm      (confirm),
    .exit         (exit),
    .lock_status  (lock_status),
    .entry_buf    (entry_buf),
    .digit_cnt    (digit_cnt),
    .err_cnt      (err_cnt),
    .lockout_left (lockout_left),
    .rgb          (rgb),
    .dbg_state    (dbg_state)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  logic [15:0] m_pw;
  logic [3:0]  m_q[$];      // entered digits, oldest first
  bit          m_unlocked;
  bit          m_setting;
  bit          m_check;     // a full code is being judged this cycle
  int          m_left;
  int          m_err;

  function automatic logic [15:0] m_code();
    logic [15:0] v = '0;
    foreach (m_q[i]) v = (v << 4) | 16'(m_q[i]);
    return v;
  endfunction

  function automatic logic [15:0] disp_of(input logic [15:0] val, input int n);
`ifdef DLOCK_MASK_EN
    logic [15:0] v = '0;
    for (int i = 0; i < n; i++) v = (v << 4) | 16'hF;
    return v;
`else
    return (n == 0) ? 16'h0 : val;
`endif
  endfunction

  function automatic logic [2:0] m_rgb();
    if (m_left > 0)   return 3'b100;
    if (m_check)      return 3'b000;
    if (m_setting)    return 3'b011;
    if (m_unlocked)   return 3'b010;
    return 3'b001;
  endfunction

  task automatic model_reset();
    m_pw = PW0;
    m_q.delete();
    m_unlocked = 0;
    m_setting = 0;
    m_check = 0;
    m_left = 0;
    m_err = 0;
  endtask

  task automatic model_step(input bit dv, input logic [3:0] d, input bit cf, input bit ex);
    if (m_left > 0) begin
      m_left--;
      if (m_left == 0) m_err = 0;
    end else if (m_check) begin
      m_check = 0;
      if (m_code() == m_pw) begin
        m_unlocked = 1;
        m_err = 0;
      end else begin
        m_err++;
        if (m_err == MAX_ERR) m_left = LOCKOUT_CYC;
      end
      m_q.delete();
    end else if (m_setting) begin
      if (ex) begin
        m_setting = 0;
        m_q.delete();
      end else if (cf) begin
        if (m_q.size() == DIGITS) begin
          m_pw = m_code();
          m_q.delete();
          m_setting = 0;
        end
      end else if (dv && m_q.size() < DIGITS) begin
        m_q.push_back(d);
      end
    end else if (m_unlocked) begin
      if (ex) m_unlocked = 0;
      else if (cf) m_setting = 1;
    end else begin
      if (ex) m_q.delete();
      else if (cf) begin
        if (m_q.size() == DIGITS) m_check = 1;
      end else if (dv && m_q.size() < DIGITS) begin
        m_q.push_back(d);
      end
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    chk("m_lock",  32'(lock_status),  32'(m_unlocked));
    chk("m_rgb",   32'(rgb),          32'(m_rgb()));
    chk("m_buf",   32'(entry_buf),    32'(disp_of(m_code(), m_q.size())));
    chk("m_cnt",   32'(digit_cnt),    32'(m_q.size()));
    chk("m_err",   32'(err_cnt),      32'(m_err));
    chk("m_left",  32'(lockout_left), 32'(m_left));
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_lock"}, 32'(lock_status),  32'(0));
    chk({tag, "_buf"},  32'(entry_buf),    32'(0));
    chk({tag, "_cnt"},  32'(digit_cnt),    32'(0));
    chk({tag, "_err"},  32'(err_cnt),      32'(0));
    chk({tag, "_left"}, 32'(lockout_left), 32'(0));
    chk({tag, "_rgb"},  32'(rgb),          32'(3'b001));
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle(input bit dv, input logic [3:0] d, input bit cf, input bit ex);
    digit_vld = dv; digit_in = d; confirm = cf; exit = ex;
    @(posedge clk);
    model_step(dv, d, cf, ex);
    #1;
    digit_vld = 0; confirm = 0; exit = 0;
    check_model();
  endtask

  task automatic press(input logic [3:0] d); cycle(1, d, 0, 0); endtask
  task automatic cnf();  cycle(0, 4'h0, 1, 0); endtask
  task automatic ext();  cycle(0, 4'h0, 0, 1); endtask
  task automatic idle(); cycle(0, 4'h0, 0, 0); endtask

  task automatic enter_code(input logic [15:0] code);
    logic [15:0] c;
    c = code;
    for (int i = 0; i < DIGITS; i++) begin
      press(c[15:12]);
      c = c << 4;
    end
  endtask

  task automatic do_reset();
    reset_n = 0;
    model_reset();
    @(posedge clk);
    #1;
    check_reset_values("rst");
    @(posedge clk);
    #1;
    reset_n = 1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    do_reset();

    // correct code unlocks with 2-cycle latency after confirm
    enter_code(16'h1234);
    chk("buf_1234", 32'(entry_buf), 32'(disp_of(16'h1234, 4)));
    chk("cnt_4", 32'(digit_cnt), 32'(4));
    cnf();
    chk("check_rgb", 32'(rgb), 32'(3'b000));
    chk("check_lock", 32'(lock_status), 32'(0));
    idle();
    chk("open_lock", 32'(lock_status), 32'(1));
    chk("open_rgb", 32'(rgb), 32'(3'b010));
    chk("open_err", 32'(err_cnt), 32'(0));

    // short confirm ignored, fifth digit dropped
    ext();
    chk("relock_rgb", 32'(rgb), 32'(3'b001));
    press(4'h1); press(4'h2); press(4'h3);
    cnf();
    chk("short_cnf_rgb", 32'(rgb), 32'(3'b001));
    chk("short_cnf_cnt", 32'(digit_cnt), 32'(3));
    press(4'h4); press(4'h5);
    chk("sat_buf", 32'(entry_buf), 32'(disp_of(16'h1234, 4)));
    chk("sat_cnt", 32'(digit_cnt), 32'(4));
    ext();
    chk("exit_clr", 32'(digit_cnt), 32'(0));

    // three failures, lockout of exactly LOCKOUT_CYC cycles
    for (int k = 1; k <= MAX_ERR; k++) begin
      enter_code(16'h0000);
      cnf();
      idle();
      chk("fail_err", 32'(err_cnt), 32'(k));
    end
    chk("lock_left_first", 32'(lockout_left), 32'(LOCKOUT_CYC));
    chk("lock_rgb", 32'(rgb), 32'(3'b100));
    for (int i = 1; i < LOCKOUT_CYC; i++) begin
      cycle(1, 4'(i), (i == 3), (i == 5));
      chk("lock_left", 32'(lockout_left), 32'(LOCKOUT_CYC - i));
    end
    press(4'h5);
    chk("post_lock_rgb", 32'(rgb), 32'(3'b001));
    chk("post_lock_err", 32'(err_cnt), 32'(0));
    chk("post_lock_cnt", 32'(digit_cnt), 32'(0));

    // change password while unlocked
    enter_code(16'h1234); cnf(); idle();
    cnf();
    chk("set_rgb", 32'(rgb), 32'(3'b011));
    enter_code(16'h9876);
    cnf();
    chk("set_done_rgb", 32'(rgb), 32'(3'b010));
    ext();
    enter_code(16'h1234); cnf(); idle();
    chk("old_pw_fails", 32'(lock_status), 32'(0));
    chk("old_pw_err", 32'(err_cnt), 32'(1));
    enter_code(16'h9876); cnf(); idle();
    chk("new_pw_opens", 32'(lock_status), 32'(1));

    // exit beats confirm on a full buffer
    ext();
    enter_code(16'h9876);
    cycle(0, 4'h0, 1, 1);
    chk("exit_cnf_cnt", 32'(digit_cnt), 32'(0));
    idle();
    chk("exit_cnf_rgb", 32'(rgb), 32'(3'b001));
    chk("exit_cnf_lock", 32'(lock_status), 32'(0));

    // random pulses, digits biased toward the current password
    for (int n = 0; n < 600; n++) begin
      int r;
      logic [3:0] d;
      r = $urandom_range(0, 11);
      if ($urandom_range(0, 2) != 0 && m_q.size() < DIGITS)
        d = 4'((m_pw >> ((DIGITS - 1 - m_q.size()) * 4)) & 16'hF);
      else
        d = 4'($urandom_range(0, 15));
      case (r)
        0, 1, 2, 3, 4, 5: cycle(1, d, 0, 0);
        6, 7:             cycle(0, d, 1, 0);
        8:                cycle(0, d, 0, 1);
        9:                cycle(1, d, 1, 1);
        10:               cycle(1, d, 1, 0);
        default:          cycle(0, d, 0, 0);
      endcase
    end

    // asynchronous reset mid-lockout restores the default password
    do_reset();
    enter_code(16'h1234); cnf(); idle();
    cnf(); enter_code(16'h5555); cnf(); ext();
    for (int k = 0; k < MAX_ERR; k++) begin
      enter_code(16'h0000); cnf(); idle();
    end
    idle(); idle();
    chk("pre_rst_rgb", 32'(rgb), 32'(3'b100));
    reset_n = 0;
    model_reset();
    #2;
    check_reset_values("async_rst");
    @(posedge clk);
    #1;
    reset_n = 1;
    enter_code(16'h1234); cnf(); idle();
    chk("default_pw_back", 32'(lock_status), 32'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
